// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache address and fills the IF/ID register.
// Holds the PC across misses, absorbs decode stalls, and sequences redirects (including mid-miss).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MISS_CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [31:0]           PC_OUT,
  input  logic [31:0]           CACHE_RDATA,
  input  logic                  CACHE_HIT,
  input  logic                  REDIRECT,
  input  logic [31:0]           REDIRECT_PC,
  input  logic                  ID_STALL,
  output logic [31:0]           IR,
  output logic [31:0]           IR_PC,
  output logic                  IR_VALID,
  output logic                  FETCH_STALL,
  output logic [MISS_CNT_W-1:0] MISS_COUNT
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MISS       = 2'd1,
    MISS_REDIR = 2'd2
  } state_t;

  state_t                state;
  logic [31:0]           pc_q;
  logic [31:0]           pending_pc;
  logic [31:0]           ir_q;
  logic [31:0]           ir_pc_q;
  logic                  ir_valid_q;
  logic                  fetch_stall_q;
  logic [MISS_CNT_W-1:0] miss_cnt_q;
  logic [31:0]           redir_aligned;

  // Masking (rather than slicing) keeps every REDIRECT_PC bit in use.
  assign redir_aligned = REDIRECT_PC & ~32'h0000_0003;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      pending_pc    <= '0;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      fetch_stall_q <= 1'b0;
      miss_cnt_q    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (REDIRECT) begin
            pc_q       <= redir_aligned;
            ir_valid_q <= 1'b0;
          end else if (ID_STALL && ir_valid_q) begin
            // decode back-pressure: everything holds, cache result ignored
          end else if (CACHE_HIT) begin
            ir_q       <= CACHE_RDATA;
            ir_pc_q    <= pc_q;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_q + 32'd4;
          end else begin
            ir_valid_q    <= 1'b0;
            state         <= MISS;
            fetch_stall_q <= 1'b1;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
          end
        end
        MISS: begin
          if (REDIRECT && CACHE_HIT) begin
            pc_q          <= redir_aligned;
            state         <= RUN;
            fetch_stall_q <= 1'b0;
          end else if (REDIRECT) begin
            pending_pc <= redir_aligned;
            state      <= MISS_REDIR;
          end else if (CACHE_HIT) begin
            ir_q          <= CACHE_RDATA;
            ir_pc_q       <= pc_q;
            ir_valid_q    <= 1'b1;
            pc_q          <= pc_q + 32'd4;
            state         <= RUN;
            fetch_stall_q <= 1'b0;
          end
        end
        MISS_REDIR: begin
          if (CACHE_HIT) begin
            pc_q          <= REDIRECT ? redir_aligned : pending_pc;
            state         <= RUN;
            fetch_stall_q <= 1'b0;
          end else if (REDIRECT) begin
            pending_pc <= redir_aligned;
          end
        end
        default: begin
          state         <= RUN;
          fetch_stall_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC_OUT      = pc_q;
  assign IR          = ir_q;
  assign IR_PC       = ir_pc_q;
  assign IR_VALID    = ir_valid_q;
  assign FETCH_STALL = fetch_stall_q;
  assign MISS_COUNT  = miss_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed test-plan sequences plus random traffic, all checked
// against an abstract fetch model; a second small instance covers PC wrap and counter saturation.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC_OUT, CACHE_RDATA, REDIRECT_PC, IR, IR_PC;
  logic        CACHE_HIT, REDIRECT, ID_STALL, IR_VALID, FETCH_STALL;
  logic [15:0] MISS_COUNT;

  logic        s_rst, s_hit, s_valid, s_stall;
  logic [31:0] s_pc, s_ir, s_irpc;
  logic [3:0]  s_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 CLK = ~CLK;

  if_fetch_unit u_dut (
    .CLK(CLK), .RST(RST), .PC_OUT(PC_OUT), .CACHE_RDATA(CACHE_RDATA),
    .CACHE_HIT(CACHE_HIT), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .ID_STALL(ID_STALL), .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID),
    .FETCH_STALL(FETCH_STALL), .MISS_COUNT(MISS_COUNT)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MISS_CNT_W(4)) u_sat (
    .CLK(CLK), .RST(s_rst), .PC_OUT(s_pc), .CACHE_RDATA(32'h1234_5678),
    .CACHE_HIT(s_hit), .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
    .ID_STALL(1'b0), .IR(s_ir), .IR_PC(s_irpc), .IR_VALID(s_valid),
    .FETCH_STALL(s_stall), .MISS_COUNT(s_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Abstract model: "waiting" means a fill is outstanding, "have_pend" a redirect queued behind it.
  logic [31:0] m_pc, m_pend, m_ir, m_irpc;
  bit          m_v, m_waiting, m_have_pend;
  int unsigned m_misses;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_edge();
    if (!RST) begin
      m_pc = 32'h0; m_pend = 32'h0; m_ir = 32'h0; m_irpc = 32'h0;
      m_v = 0; m_waiting = 0; m_have_pend = 0; m_misses = 0;
    end else if (!m_waiting) begin
      if (REDIRECT) begin
        m_pc = align(REDIRECT_PC); m_v = 0;
      end else if (ID_STALL && m_v) begin
      end else if (CACHE_HIT) begin
        m_ir = CACHE_RDATA; m_irpc = m_pc; m_v = 1; m_pc = m_pc + 32'd4;
      end else begin
        m_v = 0; m_waiting = 1; m_have_pend = 0; m_misses++;
      end
    end else if (!m_have_pend) begin
      if (REDIRECT && CACHE_HIT) begin
        m_pc = align(REDIRECT_PC); m_waiting = 0;
      end else if (REDIRECT) begin
        m_pend = align(REDIRECT_PC); m_have_pend = 1;
      end else if (CACHE_HIT) begin
        m_ir = CACHE_RDATA; m_irpc = m_pc; m_v = 1; m_pc = m_pc + 32'd4; m_waiting = 0;
      end
    end else begin
      if (CACHE_HIT) begin
        m_pc = REDIRECT ? align(REDIRECT_PC) : m_pend; m_waiting = 0;
      end else if (REDIRECT) begin
        m_pend = align(REDIRECT_PC);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pc_out", PC_OUT, m_pc);
    check_eq("ir", IR, m_ir);
    check_eq("ir_pc", IR_PC, m_irpc);
    check_eq("ir_valid", {31'b0, IR_VALID}, {31'b0, m_v});
    check_eq("fetch_stall", {31'b0, FETCH_STALL}, {31'b0, m_waiting});
    check_eq("miss_count", {16'b0, MISS_COUNT}, (m_misses > 65535) ? 32'hFFFF : m_misses);
  endtask

  task automatic step(input logic rst, input logic hit, input logic redir,
                      input logic [31:0] rpc, input logic stall);
    RST = rst; CACHE_HIT = hit; REDIRECT = redir; REDIRECT_PC = rpc; ID_STALL = stall;
    CACHE_RDATA = hit ? (PC_OUT ^ 32'hA5A5_A5A5) : $urandom;
    @(posedge CLK);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    RST = 1'b0; CACHE_HIT = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; ID_STALL = 1'b0;
    CACHE_RDATA = '0; s_rst = 1'b0; s_hit = 1'b0;

    // 1: reset, then streaming hits
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check_eq("reset_pc", PC_OUT, 32'h0);
    for (int unsigned i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    check_eq("stream_pc", PC_OUT, 32'h10);
    check_eq("stream_ir", IR, 32'h0000_000C ^ 32'hA5A5_A5A5);

    // 2: five-cycle miss at 0x10
    for (int unsigned i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    check_eq("miss_hold_pc", PC_OUT, 32'h10);
    step(1, 1, 0, 0, 0);
    check_eq("miss_done_irpc", IR_PC, 32'h10);
    check_eq("miss_done_cnt", {16'b0, MISS_COUNT}, 32'd1);

    // 3: decode stall for three cycles while IR_PC=0x8
    step(1, 0, 1, 32'h4, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_eq("pre_stall_irpc", IR_PC, 32'h8);
    for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, 0, 1);
    check_eq("stall_pc", PC_OUT, 32'hC);
    step(1, 1, 0, 0, 0);
    check_eq("resume_irpc", IR_PC, 32'hC);

    // 4: miss at 0x20 with two mid-miss redirects
    step(1, 0, 1, 32'h20, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h103, 0);
    step(1, 0, 1, 32'h200, 0);
    step(1, 0, 0, 0, 0);
    check_eq("redir_hold_pc", PC_OUT, 32'h20);
    step(1, 1, 0, 0, 0);
    check_eq("redir_target", PC_OUT, 32'h200);

    // 5: redirect beats decode stall
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h40, 1);
    check_eq("redir_stall_pc", PC_OUT, 32'h40);

    // 6c: reset mid-miss
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("rst_mid_miss_stall", {31'b0, FETCH_STALL}, 32'd0);

    // Random traffic, occasional reset
    for (int unsigned i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 4) == 0));

    // 6a/6b: PC wrap and counter saturation on the narrow instance
    s_rst = 1'b0; s_hit = 1'b1;
    @(posedge CLK); #1;
    s_rst = 1'b1;
    check_eq("wrap_f8", s_pc, 32'hFFFF_FFF8);
    @(posedge CLK); #1 check_eq("wrap_fc", s_pc, 32'hFFFF_FFFC);
    @(posedge CLK); #1 check_eq("wrap_0", s_pc, 32'h0);
    for (int unsigned i = 0; i < 19; i++) begin
      s_hit = 1'b0; @(posedge CLK); #1;
      if (i == 14) check_eq("sat_at_15", {28'b0, s_cnt}, 32'd15);
      s_hit = 1'b1; @(posedge CLK); #1;
    end
    check_eq("sat_hold", {28'b0, s_cnt}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the L1 instruction-cache memory wrapper.
- Owns the program counter and drives it as the cache address.
- Consumes the cache's read data and hit flag, and produces the IF/ID pipeline register for decode.
- Holds the PC steady through cache misses, absorbs decode back-pressure, and sequences branch/jump redirects, including redirects that arrive mid-miss.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- MISS_CNT_W, 16, width of the saturating miss counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-low.
- PC_OUT  out  32  fetch address to the instruction cache.
- CACHE_RDATA  in  32  instruction word for PC_OUT; combinational response, valid in the same cycle when CACHE_HIT=1.
- CACHE_HIT  in  1  1 = CACHE_RDATA valid for the current PC_OUT; 0 = miss, fill in progress.
- REDIRECT  in  1  taken branch/jump from execute, single-cycle pulse.
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored and treated as 0.
- ID_STALL  in  1  decode cannot accept a new instruction this cycle.
- IR  out  32  fetched instruction (IF/ID register).
- IR_PC  out  32  address of IR.
- IR_VALID  out  1  IR/IR_PC hold a live instruction.
- FETCH_STALL  out  1  registered; 1 while a miss is outstanding.
- MISS_COUNT  out  MISS_CNT_W  number of misses since reset; saturates at all-ones.

Behaviour:
- Reset (RST=0 at clock edge): pc_q=RESET_PC, state=RUN, IR=0, IR_PC=0, IR_VALID=0, FETCH_STALL=0, MISS_COUNT=0, pending_pc=0. Reset overrides every other input, including mid-miss; the cache fill already in flight is not tracked.
- PC_OUT = pc_q at all times (registered, no combinational path from any input).
- PC increment is pc_q+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- States: RUN, MISS, MISS_REDIR.
- RUN, evaluated in priority order:
  1. REDIRECT: pc_q <= {REDIRECT_PC[31:2],2'b00}; IR_VALID <= 0. The current cache result is discarded, even when ID_STALL is set.
  2. ID_STALL & IR_VALID: hold pc_q, IR, IR_PC and IR_VALID; CACHE_HIT is ignored.
  3. CACHE_HIT: IR <= CACHE_RDATA; IR_PC <= pc_q; IR_VALID <= 1; pc_q <= pc_q+4. Sustains one instruction per cycle.
  4. Otherwise (miss): IR_VALID <= 0; state <= MISS; FETCH_STALL <= 1; MISS_COUNT increments (saturating).
- MISS: pc_q is held; PC_OUT must not change while the fill is outstanding.
  - REDIRECT & CACHE_HIT in the same cycle: discard the data; pc_q <= aligned REDIRECT_PC; state RUN; FETCH_STALL <= 0.
  - REDIRECT alone: pending_pc <= aligned REDIRECT_PC; state MISS_REDIR.
  - CACHE_HIT alone: load IR/IR_PC, set IR_VALID=1, pc_q <= pc_q+4, state RUN, FETCH_STALL <= 0. IR_VALID is 0 here, so ID_STALL is irrelevant.
- MISS_REDIR: pc_q is held.
  - A new REDIRECT overwrites pending_pc (the latest redirect wins).
  - On CACHE_HIT: data discarded; IR_VALID stays 0; pc_q <= pending_pc, or REDIRECT_PC if REDIRECT is asserted in the same cycle; state RUN; FETCH_STALL <= 0.
- Every transition out of MISS or MISS_REDIR clears FETCH_STALL on the same edge.
- MISS_COUNT counts only RUN->MISS transitions and never wraps.
- A miss detected on a redirected PC counts as a new miss.
- No X propagation: IR/IR_PC retain old values when IR_VALID=0.

Test Plan:
1. Reset, then CACHE_HIT=1 constant with CACHE_RDATA=PC^32'hA5A5_A5A5 -> PC_OUT sequence 0,4,8,C; IR_PC lags PC_OUT by one cycle; IR_VALID=1 from the 2nd cycle; MISS_COUNT=0.
2. At PC_OUT=0x10, hold CACHE_HIT=0 for 5 cycles, then 1 -> PC_OUT stays 0x10 for 6 cycles; FETCH_STALL=1 for 5 cycles; IR_VALID=0 during the miss; IR_PC=0x10 afterwards; MISS_COUNT=1.
3. Hits streaming; assert ID_STALL for 3 cycles while IR_PC=0x8 -> IR, IR_PC=0x8 and PC_OUT=0xC all frozen; streaming resumes with IR_PC=0xC.
4. Miss at 0x20; after 2 cycles REDIRECT to 0x103 (then 0x200 one cycle later); CACHE_HIT at cycle 6 -> PC_OUT held at 0x20 until the hit; data discarded; next PC_OUT=0x200; no IR_VALID for 0x20.
5. REDIRECT to 0x40 coincident with ID_STALL=1 and IR_VALID=1 -> IR_VALID=0 next cycle; PC_OUT=0x40.
6. RESET_PC=0xFFFF_FFF8, hits streaming -> PC_OUT F8, FC, 0. Separately, force 2^MISS_CNT_W+3 misses -> MISS_COUNT stays at all-ones. Assert RST=0 mid-miss -> all outputs at reset values on the next edge.
